// File: rtl/parity_combination_walker.sv
`timescale 1ns/1ps
// parity_combination_walker
// Sequencer in front of parity_to_combination_table. On a command it
// optionally pulses a table rebuild, then walks the linked list of
// combinations for one parity (find_first, then find_next until the table
// reports no successor) and streams every combination on a valid/ready port.
// It is the only driver of the table's request pins.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   cmd_*                 walk request (valid/ready), rebuild flag, parity
//   abort                 drop the current walk and return to IDLE
//   out_*                 combination stream, out_last marks the final one
//   walk_done/empty/count end-of-walk pulse, empty flag, accepted count
//   tbl_*                 request/response pins of the table
//   dbg_state             current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid never waits on ready, and the payload is held stable
// while valid is high and ready is low. This applies to cmd_* and out_*.
module parity_combination_walker #(
  parameter int MACHINE_COUNT    = 10,
  parameter int MAX_BUTTON_COUNT = 13,
  localparam int CW              = MAX_BUTTON_COUNT + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_rebuild,
  input  logic [MACHINE_COUNT-1:0] cmd_parity,
  input  logic                     abort,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            out_combination,
  output logic                     out_last,
  output logic                     walk_done,
  output logic                     walk_empty,
  output logic [CW-1:0]            walk_count,
  output logic                     tbl_build,
  output logic                     tbl_find_first,
  output logic                     tbl_find_next,
  output logic [MACHINE_COUNT-1:0] tbl_parity,
  output logic [CW-1:0]            tbl_prev,
  input  logic                     tbl_complete,
  input  logic                     tbl_ready,
  input  logic                     tbl_list_created,
  input  logic                     tbl_next_valid,
  input  logic [CW-1:0]            tbl_first,
  input  logic [CW-1:0]            tbl_next,
  output logic [3:0]               dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_BUILD, S_WAIT_BUILD, S_REQ_FIRST, S_WAIT_FIRST,
    S_REQ_PEEK, S_WAIT_PEEK, S_EMIT, S_DONE
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [MACHINE_COUNT-1:0]   r_parity;
  logic [CW-1:0]              r_cur;
  logic [CW-1:0]              r_la;
  logic                       r_la_valid;
  logic [CW-1:0]              r_count;
  logic                       r_tbl_build;
  logic                       r_tbl_ff;
  logic                       r_tbl_fn;
  logic                       w_accept;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (cmd_valid) w_next = cmd_rebuild ? S_BUILD : S_REQ_FIRST;
      S_BUILD:      w_next = S_WAIT_BUILD;
      S_WAIT_BUILD: if (tbl_complete) w_next = S_REQ_FIRST;
      S_REQ_FIRST:  w_next = S_WAIT_FIRST;
      S_WAIT_FIRST: if (tbl_ready) w_next = tbl_list_created ? S_REQ_PEEK : S_DONE;
      S_REQ_PEEK:   w_next = S_WAIT_PEEK;
      S_WAIT_PEEK:  if (tbl_ready) w_next = S_EMIT;
      S_EMIT:       if (out_ready) w_next = r_la_valid ? S_REQ_PEEK : S_DONE;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
    // abort overrides everything, including an accept in EMIT
    if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  assign w_accept = (r_state == S_EMIT) && out_ready && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tbl_build <= 1'b0;
      r_tbl_ff    <= 1'b0;
      r_tbl_fn    <= 1'b0;
      r_parity    <= '0;
      r_cur       <= '0;
      r_la        <= '0;
      r_la_valid  <= 1'b0;
      r_count     <= '0;
    end else begin
      // request pins are flops that are high exactly during their request state
      r_tbl_build <= (w_next == S_BUILD);
      r_tbl_ff    <= (w_next == S_REQ_FIRST);
      r_tbl_fn    <= (w_next == S_REQ_PEEK);
      if ((r_state == S_IDLE) && cmd_valid) begin
        r_parity <= cmd_parity;
        r_count  <= '0;
      end
      if ((r_state == S_WAIT_FIRST) && tbl_ready && tbl_list_created)
        r_cur <= tbl_first;
      // lookahead: knowing the successor before emitting makes out_last exact
      if ((r_state == S_WAIT_PEEK) && tbl_ready) begin
        r_la_valid <= tbl_next_valid;
        r_la       <= tbl_next;
      end
      if (w_accept) begin
        if (r_count != {CW{1'b1}}) r_count <= r_count + CW'(1);
        if (r_la_valid) r_cur <= r_la;
      end
    end
  end

  assign cmd_ready       = (r_state == S_IDLE);
  assign out_valid       = (r_state == S_EMIT);
  assign out_last        = (r_state == S_EMIT) && !r_la_valid;
  assign out_combination = r_cur;
  assign walk_done       = (r_state == S_DONE);
  assign walk_empty      = (r_state == S_DONE) && (r_count == '0);
  assign walk_count      = r_count;
  assign tbl_build       = r_tbl_build;
  assign tbl_find_first  = r_tbl_ff;
  assign tbl_find_next   = r_tbl_fn;
  assign tbl_parity      = r_parity;
  // find_next is always asked about the combination currently held
  assign tbl_prev        = r_cur;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_parity_combination_walker.sv
`timescale 1ns/1ps
// Bench for parity_combination_walker. A behavioural table model answers
// requests from a button set: combination c selects buttons by its bits and
// its parity is the XOR of the selected buttons; a list holds all c < bound
// with a given parity in ascending order.
module tb_parity_combination_walker;
  localparam int MC = 10;
  localparam int MBC = 13;
  localparam int CW = MBC + 1;
  localparam int NB = CW;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic           cmd_valid = 1'b0, cmd_ready, cmd_rebuild = 1'b0;
  logic [MC-1:0]  cmd_parity = '0;
  logic           abort = 1'b0;
  logic           out_valid, out_ready = 1'b0, out_last;
  logic [CW-1:0]  out_combination;
  logic           walk_done, walk_empty;
  logic [CW-1:0]  walk_count;
  logic           tbl_build, tbl_find_first, tbl_find_next;
  logic [MC-1:0]  tbl_parity;
  logic [CW-1:0]  tbl_prev;
  logic           tbl_complete = 1'b1, tbl_ready = 1'b0;
  logic           tbl_list_created = 1'b0, tbl_next_valid = 1'b0;
  logic [CW-1:0]  tbl_first = '0, tbl_next = '0;
  logic [3:0]     dbg_state;

  parity_combination_walker #(.MACHINE_COUNT(MC), .MAX_BUTTON_COUNT(MBC)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rebuild(cmd_rebuild),
    .cmd_parity(cmd_parity), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_combination(out_combination),
    .out_last(out_last), .walk_done(walk_done), .walk_empty(walk_empty),
    .walk_count(walk_count), .tbl_build(tbl_build), .tbl_find_first(tbl_find_first),
    .tbl_find_next(tbl_find_next), .tbl_parity(tbl_parity), .tbl_prev(tbl_prev),
    .tbl_complete(tbl_complete), .tbl_ready(tbl_ready),
    .tbl_list_created(tbl_list_created), .tbl_next_valid(tbl_next_valid),
    .tbl_first(tbl_first), .tbl_next(tbl_next), .dbg_state(dbg_state)
  );

  // table contents requested by the bench (applied by the model on tbl_build)
  logic [MC-1:0] p_btn [NB] = '{default: '0};
  int            p_bound = 1;
  // contents currently inside the table model
  logic [MC-1:0] m_btn [NB] = '{default: '0};
  int            m_bound = 1;
  int            m_cnt = 0;

  function automatic logic [MC-1:0] xor_of(input logic [MC-1:0] b [NB], input int c);
    logic [MC-1:0] x;
    x = '0;
    for (int i = 0; i < NB; i++) if (c[i]) x ^= b[i];
    return x;
  endfunction

  function automatic int tbl_search(input int from, input logic [MC-1:0] p);
    for (int c = from; c < m_bound; c++) if (xor_of(m_btn, c) == p) return c;
    return -1;
  endfunction

  // table model: responds one cycle after a request; build takes 3 cycles
  always @(posedge clk) begin : table_model
    int f;
    tbl_ready <= 1'b0;
    if (tbl_build) begin
      m_btn        <= p_btn;
      m_bound      <= p_bound;
      tbl_complete <= 1'b0;
      m_cnt        <= 3;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) tbl_complete <= 1'b1;
    end
    if (tbl_find_first) begin
      f = tbl_search(0, tbl_parity);
      tbl_ready        <= 1'b1;
      tbl_list_created <= (f >= 0);
      tbl_first        <= (f >= 0) ? CW'(f) : '0;
    end
    if (tbl_find_next) begin
      f = tbl_search(int'(tbl_prev) + 1, tbl_parity);
      tbl_ready      <= 1'b1;
      tbl_next_valid <= (f >= 0);
      tbl_next       <= (f >= 0) ? CW'(f) : '0;
    end
  end

  // scoreboard
  logic [CW-1:0] exp_q [$];
  int n_cmp = 0, n_err = 0;
  int n_build = 0, n_pulse = 0, n_done = 0;
  logic          p_stall = 1'b0;
  logic [CW-1:0] p_comb = '0;
  logic          p_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tick: inspect the current cycle, then advance to the next negedge
  task automatic tick();
    logic [CW-1:0] e;
    int np;
    if (!reset) begin
      if (p_stall && out_valid) begin
        check("stall_comb", 32'(out_combination), 32'(p_comb));
        check("stall_last", 32'(out_last), 32'(p_last));
      end
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) begin
          check("extra_output", 32'(out_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("out_comb", 32'(out_combination), 32'(e));
          check("out_last", 32'(out_last), 32'(exp_q.size() == 0));
        end
      end
      if (walk_done) n_done++;
      p_stall = out_valid && !out_ready;
      p_comb  = out_combination;
      p_last  = out_last;
    end else begin
      p_stall = 1'b0;
    end
    np = int'(tbl_build) + int'(tbl_find_first) + int'(tbl_find_next);
    if (np != 0) begin
      n_pulse++;
      check("tbl_onehot", 32'(np), 32'(1));
    end
    if (tbl_build) n_build++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_out_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (out_valid) seen = 1'b1;
      else tick();
    end
    check({tag, "_valid_seen"}, 32'(seen), 32'(1));
  endtask

  task automatic run_walk(input bit rb, input logic [MC-1:0] p, input int pct,
                          input int stall_n, input string tag);
    int exp_n, b0, stalls;
    bit seen;
    exp_q.delete();
    for (int c = 0; c < p_bound; c++)
      if (xor_of(p_btn, c) == p) exp_q.push_back(CW'(c));
    exp_n  = exp_q.size();
    b0     = n_build;
    stalls = stall_n;
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
    cmd_valid = 1'b1; cmd_rebuild = rb; cmd_parity = p; out_ready = 1'b1;
    tick();
    cmd_rebuild = 1'($urandom); cmd_parity = MC'($urandom);
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      if (walk_done) seen = 1'b1;
      else begin
        // stray commands during the walk must be ignored
        cmd_valid = ($urandom_range(0, 3) == 0);
        if (out_valid && stalls > 0) begin
          out_ready = 1'b0;
          stalls--;
        end else out_ready = ($urandom_range(1, 100) <= 32'(pct));
        tick();
      end
    end
    cmd_valid = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'(1));
    check({tag, "_empty"}, 32'(walk_empty), 32'(exp_n == 0));
    check({tag, "_count"}, 32'(walk_count), 32'(exp_n));
    check({tag, "_sb_left"}, 32'(exp_q.size()), 32'(0));
    check({tag, "_builds"}, 32'(n_build - b0), 32'(rb));
    tick();
    check({tag, "_done_pulse"}, 32'(walk_done), 32'(0));
    check({tag, "_count_held"}, 32'(walk_count), 32'(exp_n));
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d0, n0, np;
    bit seen;
    logic [MC-1:0] p;
    // reset state
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_walk_done", 32'(walk_done), 32'(0));
    check("rst_walk_count", 32'(walk_count), 32'(0));
    check("rst_tbl_req", 32'({tbl_build, tbl_find_first, tbl_find_next}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // buttons {01,10,11}, bound 8: parity 00 -> {0,7}, parity 11 -> {3,4}
    p_btn[0] = MC'(1); p_btn[1] = MC'(2); p_btn[2] = MC'(3); p_bound = 8;
    run_walk(1'b1, MC'(0), 100, 0, "t1");
    run_walk(1'b0, MC'(3), 100, 0, "t2");
    run_walk(1'b0, MC'(10'h3ff), 100, 0, "t3");
    run_walk(1'b0, MC'(0), 100, 5, "t4");

    // abort in WAIT_PEEK, then a complete walk
    exp_q.delete();
    cmd_valid = 1'b1; cmd_rebuild = 1'b0; cmd_parity = MC'(3); out_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (tbl_find_next) seen = 1'b1;
      else tick();
    end
    check("t5_peek_seen", 32'(seen), 32'(1));
    tick();
    abort = 1'b1;
    d0 = n_done;
    tick();
    abort = 1'b0;
    check("t5_idle", 32'(cmd_ready), 32'(1));
    check("t5_out_valid", 32'(out_valid), 32'(0));
    repeat (4) tick();
    check("t5_no_done", 32'(n_done - d0), 32'(0));
    run_walk(1'b0, MC'(3), 100, 0, "t5b");

    // abort together with out_ready in EMIT: abort wins
    exp_q.delete();
    cmd_valid = 1'b1; cmd_parity = MC'(3); out_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    wait_out_valid("t5c");
    out_ready = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5c_count", 32'(walk_count), 32'(0));
    check("t5c_idle", 32'(cmd_ready), 32'(1));
    check("t5c_out_valid", 32'(out_valid), 32'(0));

    // asynchronous reset mid-EMIT
    out_ready = 1'b0;
    cmd_valid = 1'b1; cmd_parity = MC'(0);
    tick();
    cmd_valid = 1'b0;
    wait_out_valid("t6");
    #3 reset = 1'b1;
    #1;
    check("t6_out_valid", 32'(out_valid), 32'(0));
    check("t6_cmd_ready", 32'(cmd_ready), 32'(1));
    check("t6_count", 32'(walk_count), 32'(0));
    check("t6_tbl_req", 32'({tbl_build, tbl_find_first, tbl_find_next}), 32'(0));
    n0 = n_pulse;
    exp_q.delete();
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check("t6_no_pulse", 32'(n_pulse - n0), 32'(0));
    check("t6_idle", 32'(cmd_ready), 32'(1));

    // randomized tables and parities, each with a rebuild then a reuse walk
    for (int w = 0; w < 10; w++) begin
      np = $urandom_range(1, 5);
      for (int i = 0; i < NB; i++) p_btn[i] = (i < np) ? MC'($urandom_range(0, 7)) : '0;
      p_bound = $urandom_range(1, 1 << np);
      p = xor_of(p_btn, $urandom_range(0, p_bound - 1));
      run_walk(1'b1, p, $urandom_range(30, 100), $urandom_range(0, 3), "rnd_rb");
      if ($urandom_range(0, 3) == 0) p = MC'($urandom_range(0, 7));
      else p = xor_of(p_btn, $urandom_range(0, p_bound - 1));
      run_walk(1'b0, p, $urandom_range(30, 100), 0, "rnd_nr");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
